seg_scan_display: RTL and testbench

Time-multiplexed, parametrised seven-segment driver for the piano's display bank. It shows up to NUM_DIGITS note glyphs at once, so a chord or a short melody history can be displayed; a single-digit static note decoder can only show one note. Per-digit blanking, blinking and decimal-point control are included. Inputs go into a shadow register and become visible only at a frame boundary, so the display never tears. It sits between the note/keyboard logic and the board's common-anode display pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_display_rom.sv | 22 ++
 rtl/seg_scan_display.sv | 98 +++++++++
 tb/tb_seg_scan_display.sv | 129 ++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: note glyph codes and active-low PGFEDCBA segment patterns for the display bank.
package seg_pkg;
  localparam logic [3:0] CODE_C     = 4'h0;
  localparam logic [3:0] CODE_B     = 4'h1;
  localparam logic [3:0] CODE_A     = 4'h2;
  localparam logic [3:0] CODE_G     = 4'h3;
  localparam logic [3:0] CODE_F     = 4'h4;
  localparam logic [3:0] CODE_E     = 4'h5;
  localparam logic [3:0] CODE_D     = 4'h6;
  localparam logic [3:0] CODE_HI_C  = 4'h7;
  localparam logic [3:0] CODE_DASH  = 4'h8;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [7:0] SEG_C      = 8'hC6;
  localparam logic [7:0] SEG_B      = 8'h83;
  localparam logic [7:0] SEG_A      = 8'h88;
  localparam logic [7:0] SEG_G      = 8'h90;
  localparam logic [7:0] SEG_F      = 8'h8E;
  localparam logic [7:0] SEG_E      = 8'h86;
  localparam logic [7:0] SEG_D      = 8'hA1;
  // high C carries its own decimal point
  localparam logic [7:0] SEG_HI_C   = 8'h46;
  localparam logic [7:0] SEG_DASH   = 8'hBF;
  localparam logic [7:0] BLANK_SEG  = 8'hFF;
endpackage

// File: rtl/seg_scan_display_rom.sv
// note_glyph_rom: combinational 4-bit note code to active-low segment pattern.
module note_glyph_rom
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);
  always_comb begin
    case (code)
      CODE_C:    seg = SEG_C;
      CODE_B:    seg = SEG_B;
      CODE_A:    seg = SEG_A;
      CODE_G:    seg = SEG_G;
      CODE_F:    seg = SEG_F;
      CODE_E:    seg = SEG_E;
      CODE_D:    seg = SEG_D;
      CODE_HI_C: seg = SEG_HI_C;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = BLANK_SEG;
    endcase
  end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment scanner with frame-coherent shadow registers,
// per-digit blank/blink/dp and an all-off guard at the start of every digit slot.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int GUARD_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);
  localparam int SLOT_CYC   = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int HALF_BLINK = CLK_HZ / (2 * BLINK_HZ);
  localparam int SW = $clog2(SLOT_CYC + 1);
  localparam int BW = $clog2(HALF_BLINK + 1);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  if (NUM_DIGITS < 1 || SLOT_CYC <= GUARD_CYC) begin : g_bad_cfg
    $error("seg_scan_display: SLOT_CYC must exceed GUARD_CYC and NUM_DIGITS must be >= 1");
  end
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] dig_idx;
  logic [BW-1:0] blink_cnt;
  logic blink_on;
  logic [NUM_DIGITS-1:0][3:0] sh_codes, act_codes;
  logic [NUM_DIGITS-1:0] sh_dp, sh_blank, sh_blink, act_dp, act_blank, act_blink;
  logic slot_wrap, frame_wrap, blink_wrap, guard, dark;
  logic [3:0] cur_code;
  logic [7:0] glyph, seg_nx;
  logic [NUM_DIGITS-1:0] an_nx;
  assign slot_wrap  = slot_cnt == SW'(SLOT_CYC - 1);
  assign frame_wrap = slot_wrap && dig_idx == DW'(NUM_DIGITS - 1);
  assign blink_wrap = blink_cnt == BW'(HALF_BLINK - 1);
  assign guard      = slot_cnt < SW'(GUARD_CYC);
  assign cur_code   = act_codes[dig_idx];
  assign dark       = act_blank[dig_idx] | (act_blink[dig_idx] & ~blink_on);
  note_glyph_rom u_rom (
    .code (cur_code),
    .seg  (glyph)
  );
  // dark digits keep their anode enabled so brightness per slot stays uniform
  always_comb begin
    seg_nx = (guard || dark) ? BLANK_SEG : glyph & ~{act_dp[dig_idx], 7'b0};
    an_nx  = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!guard && dig_idx == DW'(i)) an_nx[i] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      dig_idx     <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      sh_codes    <= {NUM_DIGITS{CODE_BLANK}};
      act_codes   <= {NUM_DIGITS{CODE_BLANK}};
      sh_dp       <= '0;
      sh_blank    <= '0;
      sh_blink    <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_blink   <= '0;
      seg         <= BLANK_SEG;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      slot_cnt  <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) dig_idx <= frame_wrap ? '0 : dig_idx + 1'b1;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap) blink_on <= ~blink_on;
      if (load) begin
        sh_codes <= codes;
        sh_dp    <= dp;
        sh_blank <= blank;
        sh_blink <= blink;
      end
      // a load on the boundary cycle lands in the shadow only; active takes the old shadow
      if (frame_wrap) begin
        act_codes <= sh_codes;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        act_blink <= sh_blink;
      end
      seg         <= seg_nx;
      an          <= an_nx;
      frame_start <= slot_cnt == '0 && dig_idx == '0;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of scan order, frame coherence, masks, boundary load and reset.
module tb_seg_scan_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic [15:0] codes = '0;
  logic [3:0] dp = '0, blank = '0, blink = '0;
  logic [7:0] seg;
  logic [3:0] an;
  logic frame_start;
  int total = 0;
  int bad = 0;

  seg_scan_display #(
    .NUM_DIGITS (4),
    .CLK_HZ     (800),
    .REFRESH_HZ (50),
    .BLINK_HZ   (25),
    .GUARD_CYC  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .codes       (codes),
    .dp          (dp),
    .blank       (blank),
    .blink       (blink),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] ea, input logic [7:0] es, input logic ef);
    total += 3;
    assert (an === ea) else begin bad++; $error("FAIL %s an got %b want %b", tag, an, ea); end
    assert (seg === es) else begin bad++; $error("FAIL %s seg got %h want %h", tag, seg, es); end
    assert (frame_start === ef) else begin bad++; $error("FAIL %s frame_start got %b want %b", tag, frame_start, ef); end
  endtask

  // starts on a frame_start cycle, ends on the last cycle of that frame
  task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] e [4];
    logic [3:0] one;
    e = '{s0, s1, s2, s3};
    chk($sformatf("%s_j0", tag), 4'hF, 8'hFF, 1'b1);
    for (int j = 1; j < 16; j++) begin
      @(negedge clk);
      one = 4'b0001 << (j / 4);
      if (j % 4 == 0) chk($sformatf("%s_j%0d", tag, j), 4'hF, 8'hFF, 1'b0);
      else chk($sformatf("%s_j%0d", tag, j), ~one, e[j / 4], 1'b0);
    end
  endtask

  initial begin
    adv(3);
    chk("in_reset", 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    adv(1);
    check_frame("f0_blank", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    codes = 16'h3210;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    check_frame("f1_pre_load", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    adv(1);
    check_frame("f2_scan", 8'hC6, 8'h83, 8'h88, 8'h90);
    adv(1);
    chk("f3_g0", 4'hF, 8'hFF, 1'b1);
    adv(1);
    chk("f3_d0", 4'b1110, 8'hC6, 1'b0);
    adv(4);
    chk("f3_d1", 4'b1101, 8'h83, 1'b0);
    adv(3);
    chk("f3_g2", 4'hF, 8'hFF, 1'b0);
    codes = 16'h7654;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    chk("f3_d2_old", 4'b1011, 8'h88, 1'b0);
    adv(4);
    chk("f3_d3_old", 4'b0111, 8'h90, 1'b0);
    adv(3);
    check_frame("f4_new", 8'h8E, 8'h86, 8'hA1, 8'h46);
    dp = 4'b0001;
    blank = 4'b0100;
    blink = 4'b1000;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    check_frame("f5_mask_pre", 8'h8E, 8'h86, 8'hA1, 8'h46);
    adv(1);
    check_frame("f6_blink_on", 8'h0E, 8'h86, 8'hFF, 8'h46);
    adv(1);
    check_frame("f7_blink_off", 8'h0E, 8'h86, 8'hFF, 8'hFF);
    adv(1);
    chk("f8_g0", 4'hF, 8'hFF, 1'b1);
    adv(14);
    codes = 16'h0008;
    dp = '0;
    blank = '0;
    blink = '0;
    load = 1'b1;
    adv(1);
    load = 1'b0;
    adv(1);
    check_frame("f9_bnd_old", 8'h0E, 8'h86, 8'hFF, 8'hFF);
    adv(1);
    check_frame("f10_bnd_new", 8'hBF, 8'hC6, 8'hC6, 8'hC6);
    adv(6);
    chk("f11_d1", 4'b1101, 8'hC6, 1'b0);
    rst_n = 1'b0;
    adv(1);
    chk("mid_rst", 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    adv(1);
    chk("rst_guard", 4'hF, 8'hFF, 1'b1);
    adv(1);
    chk("rst_d0_blank", 4'b1110, 8'hFF, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
